// File: rtl/tdc_record_framer_pkg.sv
// Shared types and constants for the TDC record framer and the host-side decoder.
package tdc_record_framer_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StPop,
        StWaitRd,
        StLoad,
        StSend,
        StGuard
    } state_e;

    localparam int unsigned RecWDefault     = 48;
    localparam logic [7:0]  SyncByteDefault = 8'hA5;

    // Sync byte + one byte per 8 record bits + checksum byte.
    function automatic int unsigned frame_len(input int unsigned rec_w);
        return rec_w / 8 + 2;
    endfunction

    localparam int unsigned FrameLen = frame_len(RecWDefault);

endpackage

// File: rtl/tdc_record_framer_if.sv
// FIFO-read and byte-transmit handshake between the framer (master) and its environment.
interface tdc_record_framer_if
    import tdc_record_framer_pkg::*;
#(
    parameter int unsigned REC_W = RecWDefault
);

    logic             fifo_empty;
    logic [REC_W-1:0] fifo_dout;
    logic             fifo_rd_en;
    logic             tx_busy;
    logic [7:0]       tx_data;
    logic             new_tx_data;

    modport master (
        input  fifo_empty,
        input  fifo_dout,
        input  tx_busy,
        output fifo_rd_en,
        output tx_data,
        output new_tx_data
    );

    modport slave (
        output fifo_empty,
        output fifo_dout,
        output tx_busy,
        input  fifo_rd_en,
        input  tx_data,
        input  new_tx_data
    );

endinterface

// File: rtl/tdc_record_framer.sv
// Pops TDC records from the FIFO and streams each as a sync/data/checksum byte frame to the
// serial transmitter. New frames start only while play is high; a started frame always finishes.
module tdc_record_framer
    import tdc_record_framer_pkg::*;
#(
    parameter int unsigned REC_W     = RecWDefault,
    parameter logic [7:0]  SYNC_BYTE = SyncByteDefault
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                play,
    tdc_record_framer_if.master bus,
    output logic                frame_active,
    output logic [15:0]         frames_sent
);

    localparam int unsigned     FrmLen  = frame_len(REC_W);
    localparam int unsigned     IdxW    = $clog2(FrmLen);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(FrmLen - 1);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [REC_W-1:0] r_rec;
    logic [REC_W-1:0] w_rec_nxt;
    logic [IdxW-1:0]  r_idx;
    logic [IdxW-1:0]  w_idx_nxt;
    logic [7:0]       r_chk;
    logic [7:0]       w_chk_nxt;
    logic             r_fifo_rd_en;
    logic             w_fifo_rd_en_nxt;
    logic             r_new_tx_data;
    logic             w_new_tx_data_nxt;
    logic [7:0]       r_tx_data;
    logic [7:0]       w_tx_data_nxt;
    logic             r_frame_active;
    logic             w_frame_active_nxt;
    logic [15:0]      r_frames_sent;
    logic [15:0]      w_frames_sent_nxt;
    logic [7:0]       w_cur_byte;
    logic             w_is_data_byte;

    // Data bytes always come from the top of r_rec, which shifts left after each one is sent.
    always_comb begin
        w_is_data_byte = (r_idx != '0) && (r_idx != LastIdx);
        w_cur_byte     = r_rec[REC_W-1 -: 8];
        if (r_idx == '0) begin
            w_cur_byte = SYNC_BYTE;
        end else if (r_idx == LastIdx) begin
            w_cur_byte = r_chk;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_rec_nxt         = r_rec;
        w_idx_nxt         = r_idx;
        w_chk_nxt         = r_chk;
        w_tx_data_nxt     = r_tx_data;
        w_new_tx_data_nxt = 1'b0;
        w_frames_sent_nxt = r_frames_sent;

        unique case (r_state)
            StIdle: begin
                if (play && !bus.fifo_empty) begin
                    w_state_nxt = StPop;
                end
            end
            StPop: begin
                w_state_nxt = StWaitRd;
            end
            StWaitRd: begin
                w_state_nxt = StLoad;
            end
            StLoad: begin
                w_rec_nxt   = bus.fifo_dout;
                w_idx_nxt   = '0;
                w_chk_nxt   = 8'h00;
                w_state_nxt = StSend;
            end
            StSend: begin
                if (!bus.tx_busy) begin
                    w_new_tx_data_nxt = 1'b1;
                    w_tx_data_nxt     = w_cur_byte;
                    if (w_is_data_byte) begin
                        w_rec_nxt = r_rec << 8;
                        w_chk_nxt = r_chk ^ w_cur_byte;
                    end
                    w_state_nxt = StGuard;
                end
            end
            StGuard: begin
                if (r_idx == LastIdx) begin
                    w_frames_sent_nxt = r_frames_sent + 16'd1;
                    w_state_nxt       = StIdle;
                end else begin
                    w_idx_nxt   = r_idx + 1'b1;
                    w_state_nxt = StSend;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase

        // Decoded from the next state so both strobes leave straight from flops.
        w_fifo_rd_en_nxt   = (w_state_nxt == StPop);
        w_frame_active_nxt = (w_state_nxt != StIdle);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= StIdle;
            r_rec          <= '0;
            r_idx          <= '0;
            r_chk          <= 8'h00;
            r_fifo_rd_en   <= 1'b0;
            r_new_tx_data  <= 1'b0;
            r_tx_data      <= 8'h00;
            r_frame_active <= 1'b0;
            r_frames_sent  <= 16'h0000;
        end else begin
            r_state        <= w_state_nxt;
            r_rec          <= w_rec_nxt;
            r_idx          <= w_idx_nxt;
            r_chk          <= w_chk_nxt;
            r_fifo_rd_en   <= w_fifo_rd_en_nxt;
            r_new_tx_data  <= w_new_tx_data_nxt;
            r_tx_data      <= w_tx_data_nxt;
            r_frame_active <= w_frame_active_nxt;
            r_frames_sent  <= w_frames_sent_nxt;
        end
    end

    assign bus.fifo_rd_en  = r_fifo_rd_en;
    assign bus.new_tx_data = r_new_tx_data;
    assign bus.tx_data     = r_tx_data;
    assign frame_active    = r_frame_active;
    assign frames_sent     = r_frames_sent;

endmodule

// File: tb/tb_tdc_record_framer.sv
// Bench for tdc_record_framer: FIFO and transmitter models plus a byte scoreboard.
module tb_tdc_record_framer;
    import tdc_record_framer_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        play;
    logic        frame_active;
    logic [15:0] frames_sent;

    tdc_record_framer_if #(.REC_W(48)) bus ();

    tdc_record_framer #(
        .REC_W    (48),
        .SYNC_BYTE(8'hA5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .play        (play),
        .bus         (bus.master),
        .frame_active(frame_active),
        .frames_sent (frames_sent)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int unsigned  n_checks = 0;
    int unsigned  n_errors = 0;
    logic [47:0]  fifo_q[$];
    logic [7:0]   sb[$];
    int unsigned  strobe_cnt = 0;
    int unsigned  rd_cnt = 0;
    int unsigned  busy_len = 0;
    int unsigned  busy_cnt = 0;
    logic         prev_strobe = 1'b0;
    logic         prev_rd = 1'b0;
    logic [63:0]  exp_v;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // Queue a record into the FIFO model and its expected frame into the scoreboard.
    task automatic push_rec(input logic [47:0] rec);
        logic [7:0] b;
        logic [7:0] x;
        x = 8'h00;
        fifo_q.push_back(rec);
        sb.push_back(8'hA5);
        for (int i = 0; i < 6; i++) begin
            b = rec[47-8*i -: 8];
            x = x ^ b;
            sb.push_back(b);
        end
        sb.push_back(x);
    endtask

    task automatic wait_drain(input string tag, input int unsigned budget);
        for (int unsigned i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (sb.size() == 0 && !frame_active) break;
        end
        check_eq({tag, "_drained"}, 64'(sb.size()), 64'd0);
    endtask

    task automatic wait_strobes(input string tag, input int unsigned target,
                                input int unsigned budget);
        for (int unsigned i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (strobe_cnt >= target) break;
        end
        check_eq({tag, "_reached"}, 64'(strobe_cnt >= target), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_rd_en"}, 64'(bus.fifo_rd_en), 64'd0);
        check_eq({tag, "_new_tx"}, 64'(bus.new_tx_data), 64'd0);
        check_eq({tag, "_tx_data"}, 64'(bus.tx_data), 64'h00);
        check_eq({tag, "_active"}, 64'(frame_active), 64'd0);
        check_eq({tag, "_frames"}, 64'(frames_sent), 64'd0);
    endtask

    // FIFO, transmitter and output monitor, all evaluated away from the active edge.
    always @(negedge clk) begin
        if (bus.new_tx_data) begin
            strobe_cnt++;
            check_eq("strobe_back_to_back", 64'(prev_strobe), 64'd0);
            check_eq("strobe_while_busy", 64'(bus.tx_busy), 64'd0);
            check_eq("active_at_strobe", 64'(frame_active), 64'd1);
            exp_v = (sb.size() != 0) ? 64'(sb.pop_front()) : 64'h100;
            check_eq("tx_byte", 64'(bus.tx_data), exp_v);
            busy_cnt = busy_len;
        end else if (busy_cnt != 0) begin
            busy_cnt--;
        end
        bus.tx_busy = (busy_cnt != 0);
        if (bus.fifo_rd_en) begin
            rd_cnt++;
            check_eq("rd_while_empty", 64'(bus.fifo_empty), 64'd0);
            check_eq("rd_back_to_back", 64'(prev_rd), 64'd0);
            if (fifo_q.size() != 0) bus.fifo_dout = fifo_q.pop_front();
        end
        bus.fifo_empty = (fifo_q.size() == 0);
        prev_strobe = bus.new_tx_data;
        prev_rd     = bus.fifo_rd_en;
    end

    initial begin
        int unsigned s0;
        int unsigned r0;
        int unsigned f0;
        logic        active_seen;

        rst_n = 1'b0;
        play  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Single known record, transmitter never busy.
        @(posedge clk); #1;
        play = 1'b1;
        push_rec(48'h0123_4567_89AB);
        wait_drain("single", 200);
        check_eq("single_frames", 64'(frames_sent), 64'd1);
        check_eq("single_rd", 64'(rd_cnt), 64'd1);
        check_eq("single_strobes", 64'(strobe_cnt), 64'd8);

        // Three records against a slow transmitter.
        busy_len = 10;
        s0 = strobe_cnt;
        r0 = rd_cnt;
        for (int i = 0; i < 3; i++) push_rec(48'({$urandom(), $urandom()}));
        wait_drain("slow", 2000);
        check_eq("slow_frames", 64'(frames_sent), 64'd4);
        check_eq("slow_rd", 64'(rd_cnt - r0), 64'd3);
        check_eq("slow_strobes", 64'(strobe_cnt - s0), 64'd24);
        busy_len = 0;

        // play dropped mid-frame: frame completes, next record waits for play.
        s0 = strobe_cnt;
        r0 = rd_cnt;
        f0 = 32'(frames_sent);
        push_rec(48'hFEDC_BA98_7654);
        push_rec(48'h1111_2222_3333);
        wait_strobes("pause_byte4", s0 + 4, 200);
        play = 1'b0;
        wait_strobes("pause_tail", s0 + 8, 200);
        repeat (50) @(posedge clk);
        #1;
        check_eq("pause_rd", 64'(rd_cnt - r0), 64'd1);
        check_eq("pause_strobes", 64'(strobe_cnt - s0), 64'd8);
        check_eq("pause_frames", 64'(frames_sent), 64'(f0 + 1));
        check_eq("pause_pending", 64'(sb.size()), 64'd8);
        play = 1'b1;
        wait_drain("resume", 200);
        check_eq("resume_frames", 64'(frames_sent), 64'(f0 + 2));
        check_eq("resume_rd", 64'(rd_cnt - r0), 64'd2);

        // Empty FIFO with play high: nothing may start.
        r0 = rd_cnt;
        active_seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            active_seen = active_seen | frame_active;
        end
        check_eq("empty_rd", 64'(rd_cnt - r0), 64'd0);
        check_eq("empty_active", 64'(active_seen), 64'd0);

        // Reset during the third byte aborts the frame; the next frame is clean.
        s0 = strobe_cnt;
        push_rec(48'hDEAD_BEEF_CAFE);
        wait_strobes("abort_byte3", s0 + 3, 200);
        rst_n = 1'b0;
        sb.delete();
        @(posedge clk); #1;
        check_reset_outputs("abort");
        rst_n = 1'b1;
        push_rec(48'h0F1E_2D3C_4B5A);
        wait_drain("after_abort", 200);
        check_eq("after_abort_frames", 64'(frames_sent), 64'd1);

        // Counter wrap from 16'hFFFF.
        force dut.r_frames_sent = 16'hFFFF;
        @(posedge clk); #1;
        release dut.r_frames_sent;
        @(posedge clk); #1;
        check_eq("wrap_preload", 64'(frames_sent), 64'hFFFF);
        push_rec(48'h8000_0000_0001);
        wait_drain("wrap", 200);
        check_eq("wrap_frames", 64'(frames_sent), 64'd0);

        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
